// File: rtl/s3g_pkg.sv
// rtl/s3g_pkg.sv - shared types and constants for the s3g transmit arbiter
package s3g_pkg;

    localparam int N_REQ        = 3;
    localparam int MAX_LEN      = 15;
    localparam int WAIT_BUSY_TO = 4;

    localparam logic [1:0] NO_GRANT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RELEASE
    } state_t;

    // Next requester index in the 0 -> 1 -> 2 -> 0 rotation
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/s3g_rr_pick.sv
// rtl/s3g_rr_pick.sv - combinational winner selection (S3G_TX_ARB_PRIO_EN: requester 0 strict priority)
module s3g_rr_pick
    import s3g_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_winner,
    output logic             valid,
    output logic [1:0]       index
);

`ifdef S3G_TX_ARB_PRIO_EN
    // Requester 0 always wins; 1 and 2 alternate based on who went last
    always_comb begin
        valid = |req;
        index = 2'd0;
        if (req[0]) begin
            index = 2'd0;
        end else if (req[1] && req[2]) begin
            index = (last_winner == 2'd1) ? 2'd2 : 2'd1;
        end else if (req[1]) begin
            index = 2'd1;
        end else if (req[2]) begin
            index = 2'd2;
        end
    end
`else
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    // Search the rotation starting just after the previous winner
    always_comb begin
        cand0 = rr_next(last_winner);
        cand1 = rr_next(cand0);
        cand2 = rr_next(cand1);
        valid = |req;
        index = 2'd0;
        if (req[cand0]) begin
            index = cand0;
        end else if (req[cand1]) begin
            index = cand1;
        end else if (req[cand2]) begin
            index = cand2;
        end
    end
`endif

endmodule

// File: rtl/s3g_tx_arb.sv
// rtl/s3g_tx_arb.sv - shares one packet transmitter among 3 requesters (option: S3G_TX_ARB_PRIO_EN)
module s3g_tx_arb
    import s3g_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   req,
    input  logic [7:0]   len0,
    input  logic [7:0]   len1,
    input  logic [7:0]   len2,
    input  logic [127:0] data0,
    input  logic [127:0] data1,
    input  logic [127:0] data2,
    output logic [2:0]   ack,
    output logic [2:0]   err,
    output logic         tx_packet_wr,
    output logic [7:0]   tx_payload_len,
    output logic [127:0] tx_buf,
    input  logic         tx_busy,
    output logic [1:0]   grant_id,
    output logic         active
);

    state_t       state;
    state_t       state_next;
    logic [1:0]   last_winner;
    logic [1:0]   pick_idx;
    logic         pick_valid;
    logic         grant_fire;
    logic         len_bad;
    logic         err_flag;
    logic [1:0]   wait_cnt;
    logic         wait_expired;
    logic [7:0]   len_sel;
    logic [127:0] data_sel;

    s3g_rr_pick u_pick (
        .req         (req),
        .last_winner (last_winner),
        .valid       (pick_valid),
        .index       (pick_idx)
    );

    // Route the candidate winner's length and payload to the latch inputs
    always_comb begin
        case (pick_idx)
            2'd1:    begin len_sel = len1; data_sel = data1; end
            2'd2:    begin len_sel = len2; data_sel = data2; end
            default: begin len_sel = len0; data_sel = data0; end
        endcase
    end

    assign grant_fire   = (state == IDLE) && pick_valid && !tx_busy;
    assign len_bad      = len_sel > 8'(MAX_LEN);
    assign wait_expired = wait_cnt == 2'(WAIT_BUSY_TO - 1);

    // State register; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    state_next = len_bad ? RELEASE : LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wait_expired) begin
                    state_next = RELEASE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completion pulses: one ack bit for the owner, err alongside when flagged
    always_comb begin
        ack = '0;
        err = '0;
        if (state == RELEASE) begin
            ack = 3'b001 << grant_id;
            if (err_flag) begin
                err = 3'b001 << grant_id;
            end
        end
    end

    // Grant bookkeeping, payload latch, launch strobe and busy-wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_packet_wr   <= 1'b0;
            tx_payload_len <= '0;
            tx_buf         <= '0;
            grant_id       <= NO_GRANT;
            active         <= 1'b0;
            last_winner    <= 2'd2;
            err_flag       <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            tx_packet_wr <= (state == LAUNCH);
            if (grant_fire) begin
                tx_payload_len <= len_sel;
                tx_buf         <= data_sel;
                grant_id       <= pick_idx;
                active         <= 1'b1;
                last_winner    <= pick_idx;
                err_flag       <= len_bad;
            end else if (state == RELEASE) begin
                grant_id <= NO_GRANT;
                active   <= 1'b0;
                err_flag <= 1'b0;
            end else if (state == WAIT_BUSY && !tx_busy && wait_expired) begin
                err_flag <= 1'b1;
            end
            if (state == WAIT_BUSY) begin
                wait_cnt <= wait_cnt + 2'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_s3g_tx_arb.sv
// tb/tb_s3g_tx_arb.sv - scoreboard bench for s3g_tx_arb
module tb_s3g_tx_arb;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req;
    logic [7:0]   len0, len1, len2;
    logic [127:0] data0, data1, data2;
    logic [2:0]   ack;
    logic [2:0]   err;
    logic         tx_packet_wr;
    logic [7:0]   tx_payload_len;
    logic [127:0] tx_buf;
    logic         tx_busy;
    logic [1:0]   grant_id;
    logic         active;

    s3g_tx_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .len0           (len0),
        .len1           (len1),
        .len2           (len2),
        .data0          (data0),
        .data1          (data1),
        .data2          (data2),
        .ack            (ack),
        .err            (err),
        .tx_packet_wr   (tx_packet_wr),
        .tx_payload_len (tx_payload_len),
        .tx_buf         (tx_buf),
        .tx_busy        (tx_busy),
        .grant_id       (grant_id),
        .active         (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ack;
        logic [2:0] err;
    } exp_ack_t;

    typedef struct {
        logic [7:0]   len;
        logic [127:0] data;
    } exp_wr_t;

    exp_ack_t     exp_q[$];
    exp_wr_t      wexp_q[$];
    logic [2:0]   ack_q[$];
    logic [2:0]   err_q[$];
    int           ack_cyc_q[$];
    logic [7:0]   wr_len_q[$];
    logic [127:0] wr_buf_q[$];
    int           wr_cyc_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int busy_left = 0;
    int busy_hold = 10;
    bit tx_auto = 1'b1;
    int fall_cyc = -1;
    int multi_ack = 0;

    function automatic logic [127:0] mk_data(input logic [7:0] seed);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) begin
            d[8*k +: 8] = seed + 8'(k);
        end
        return d;
    endfunction

    task automatic push_exp(input int id, input bit bad, input bit launch,
                            input logic [7:0] l, input logic [127:0] d);
        exp_ack_t e;
        exp_wr_t  w;
        e.ack = 3'b001 << id;
        e.err = bad ? e.ack : 3'b000;
        exp_q.push_back(e);
        if (launch) begin
            w.len  = l;
            w.data = d;
            wexp_q.push_back(w);
        end
    endtask

    // One cycle: observe outputs at the falling edge, then model the transmitter
    task automatic step();
        @(negedge clk);
        cyc++;
        if (tx_packet_wr === 1'b1) begin
            wr_len_q.push_back(tx_payload_len);
            wr_buf_q.push_back(tx_buf);
            wr_cyc_q.push_back(cyc);
        end
        if (ack !== 3'b000) begin
            ack_q.push_back(ack);
            err_q.push_back(err);
            ack_cyc_q.push_back(cyc);
        end
        if ($countones(ack) > 1) multi_ack++;
        if (tx_auto && tx_packet_wr === 1'b1) busy_left = busy_hold;
        if (busy_left > 0) begin
            tx_busy = 1'b1;
            busy_left--;
        end else begin
            if (tx_busy) fall_cyc = cyc;
            tx_busy = 1'b0;
        end
    endtask

    task automatic clear_obs();
        exp_q.delete(); wexp_q.delete();
        ack_q.delete(); err_q.delete(); ack_cyc_q.delete();
        wr_len_q.delete(); wr_buf_q.delete(); wr_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 3'b000;
        tx_busy = 1'b0;
        busy_left = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        clear_obs();
    endtask

    task automatic wait_acks(input int n, input int budget, output bit ok);
        ok = (ack_q.size() >= n);
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            if (ack_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 3'b000;
        tx_busy = 1'b0;
        @(negedge clk);
        n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b, expected 000", ack); end
        n_tests++; if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b, expected 000", err); end
        n_tests++; if (tx_packet_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b, expected 0", tx_packet_wr); end
        n_tests++; if (tx_payload_len !== 8'd0) begin n_fail++; $display("FAIL reset_len: got %0d, expected 0", tx_payload_len); end
        n_tests++; if (tx_buf !== 128'd0) begin n_fail++; $display("FAIL reset_buf: got %h, expected 0", tx_buf); end
        n_tests++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL reset_grant_id: got %0d, expected 3", grant_id); end
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b, expected 0", active); end
        do_reset();
    endtask

    task automatic test_single();
        int req_cyc;
        bit ok;
        exp_ack_t e;
        exp_wr_t w;
        logic [2:0] oa, oe;
        busy_hold = 10;
        tx_auto = 1'b1;
        len0 = 8'd5;
        data0 = mk_data(8'h00);
        req = 3'b001;
        req_cyc = cyc;
        push_exp(0, 1'b0, 1'b1, 8'd5, mk_data(8'h00));
        for (int k = 0; k < 20 && wr_cyc_q.size() == 0; k++) step();
        n_tests++; if (wr_cyc_q.size() == 0) begin n_fail++; $display("FAIL single_wr_seen: got none, expected a launch"); end
        // requester withdraws and scribbles its inputs after the grant
        req = 3'b000;
        len0 = 8'd9;
        data0 = ~mk_data(8'h00);
        wait_acks(1, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_ack_timeout: got no ack, expected one"); end
        n_tests++; if (tx_payload_len !== 8'd5) begin n_fail++; $display("FAIL single_len_hold: got %0d, expected 5", tx_payload_len); end
        n_tests++; if (tx_buf !== mk_data(8'h00)) begin n_fail++; $display("FAIL single_buf_hold: got %h, expected %h", tx_buf, mk_data(8'h00)); end
        if (wr_cyc_q.size() > 0) begin
            n_tests++; if (wr_cyc_q[0] - req_cyc != 2) begin n_fail++; $display("FAIL single_wr_latency: got %0d, expected 2", wr_cyc_q[0] - req_cyc); end
        end
        if (ack_cyc_q.size() > 0) begin
            n_tests++; if (ack_cyc_q[0] - fall_cyc != 1) begin n_fail++; $display("FAIL single_ack_after_busy: got %0d, expected 1", ack_cyc_q[0] - fall_cyc); end
        end
        repeat (4) step();
        n_tests++; if (active !== 1'b0 || grant_id !== 2'd3) begin n_fail++; $display("FAIL single_idle: got active=%b grant_id=%0d, expected 0/3", active, grant_id); end
        while (ack_q.size() > 0) begin
            oa = ack_q.pop_front();
            oe = err_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_extra_ack: got ack=%b, expected none", oa); end
            else begin
                e = exp_q.pop_front();
                if (oa !== e.ack || oe !== e.err) begin n_fail++; $display("FAIL single_ack: got ack=%b err=%b, expected ack=%b err=%b", oa, oe, e.ack, e.err); end
            end
        end
        n_tests++; if (wr_len_q.size() != 1) begin n_fail++; $display("FAIL single_wr_count: got %0d, expected 1", wr_len_q.size()); end
        while (wr_len_q.size() > 0 && wexp_q.size() > 0) begin
            w = wexp_q.pop_front();
            n_tests++;
            if (wr_len_q[0] !== w.len || wr_buf_q[0] !== w.data) begin n_fail++; $display("FAIL single_wr_data: got len=%0d buf=%h, expected len=%0d buf=%h", wr_len_q[0], wr_buf_q[0], w.len, w.data); end
            void'(wr_len_q.pop_front());
            void'(wr_buf_q.pop_front());
        end
        clear_obs();
    endtask

    task automatic test_round_robin();
        bit ok;
        int n_exp;
        exp_ack_t e;
        exp_wr_t w;
        logic [2:0] oa, oe;
        do_reset();
        busy_hold = 3;
        len0 = 8'd3; len1 = 8'd4; len2 = 8'd5;
        data0 = mk_data(8'h10); data1 = mk_data(8'h20); data2 = mk_data(8'h30);
`ifdef S3G_TX_ARB_PRIO_EN
        push_exp(0, 1'b0, 1'b1, 8'd3, mk_data(8'h10));
        push_exp(0, 1'b0, 1'b1, 8'd3, mk_data(8'h10));
        push_exp(0, 1'b0, 1'b1, 8'd3, mk_data(8'h10));
        push_exp(1, 1'b0, 1'b1, 8'd4, mk_data(8'h20));
        push_exp(2, 1'b0, 1'b1, 8'd5, mk_data(8'h30));
        n_exp = 5;
`else
        push_exp(0, 1'b0, 1'b1, 8'd3, mk_data(8'h10));
        push_exp(1, 1'b0, 1'b1, 8'd4, mk_data(8'h20));
        push_exp(2, 1'b0, 1'b1, 8'd5, mk_data(8'h30));
        push_exp(0, 1'b0, 1'b1, 8'd3, mk_data(8'h10));
        n_exp = 4;
`endif
        req = 3'b111;
        for (int i = 0; i < n_exp; i++) begin
            wait_acks(i + 1, 60, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_ack_timeout: got %0d acks, expected %0d", ack_q.size(), i + 1); end
`ifdef S3G_TX_ARB_PRIO_EN
            if (i == 2) req = 3'b110;
`endif
        end
        req = 3'b000;
        repeat (10) step();
        for (int i = 0; i + 1 < ack_cyc_q.size() && i + 1 < wr_cyc_q.size(); i++) begin
            n_tests++;
            if (wr_cyc_q[i+1] - ack_cyc_q[i] != 3) begin n_fail++; $display("FAIL rr_ack_to_wr: got %0d, expected 3", wr_cyc_q[i+1] - ack_cyc_q[i]); end
        end
        while (ack_q.size() > 0) begin
            oa = ack_q.pop_front();
            oe = err_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rr_extra_ack: got ack=%b, expected none", oa); end
            else begin
                e = exp_q.pop_front();
                if (oa !== e.ack || oe !== e.err) begin n_fail++; $display("FAIL rr_ack: got ack=%b err=%b, expected ack=%b err=%b", oa, oe, e.ack, e.err); end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_missing_ack: got %0d left over, expected 0", exp_q.size()); end
        while (wr_len_q.size() > 0 && wexp_q.size() > 0) begin
            w = wexp_q.pop_front();
            n_tests++;
            if (wr_len_q[0] !== w.len || wr_buf_q[0] !== w.data) begin n_fail++; $display("FAIL rr_wr_data: got len=%0d buf=%h, expected len=%0d buf=%h", wr_len_q[0], wr_buf_q[0], w.len, w.data); end
            void'(wr_len_q.pop_front());
            void'(wr_buf_q.pop_front());
        end
        n_tests++; if (wr_len_q.size() != 0 || wexp_q.size() != 0) begin n_fail++; $display("FAIL rr_wr_count: got %0d extra, expected 0 (missing %0d)", wr_len_q.size(), wexp_q.size()); end
        clear_obs();
    endtask

    task automatic test_len_reject();
        int req_cyc;
        bit ok;
        exp_ack_t e;
        busy_hold = 3;
        len1 = 8'd16;
        data1 = mk_data(8'h40);
        push_exp(1, 1'b1, 1'b0, 8'd16, mk_data(8'h40));
        req = 3'b010;
        req_cyc = cyc;
        wait_acks(1, 20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL reject_ack_timeout: got no ack, expected one"); end
        n_tests++; if (active !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL reject_owner: got active=%b grant_id=%0d, expected 1/1", active, grant_id); end
        req = 3'b000;
        if (ack_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (ack_q[0] !== e.ack || err_q[0] !== e.err) begin n_fail++; $display("FAIL reject_ack: got ack=%b err=%b, expected ack=%b err=%b", ack_q[0], err_q[0], e.ack, e.err); end
            n_tests++; if (ack_cyc_q[0] - req_cyc != 1) begin n_fail++; $display("FAIL reject_latency: got %0d, expected 1", ack_cyc_q[0] - req_cyc); end
        end
        repeat (4) step();
        n_tests++; if (wr_cyc_q.size() != 0) begin n_fail++; $display("FAIL reject_no_wr: got %0d launches, expected 0", wr_cyc_q.size()); end
        n_tests++; if (ack_q.size() != 1) begin n_fail++; $display("FAIL reject_ack_count: got %0d, expected 1", ack_q.size()); end
        len1 = 8'd4;
        clear_obs();
    endtask

    task automatic test_timeout();
        bit ok;
        exp_ack_t e;
        tx_auto = 1'b0;
        len2 = 8'd7;
        data2 = mk_data(8'h50);
        push_exp(2, 1'b1, 1'b1, 8'd7, mk_data(8'h50));
        req = 3'b100;
        wait_acks(1, 30, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_ack_timeout: got no ack, expected one"); end
        req = 3'b000;
        if (ack_q.size() > 0 && wr_cyc_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++; if (ack_q[0] !== e.ack || err_q[0] !== e.err) begin n_fail++; $display("FAIL timeout_ack: got ack=%b err=%b, expected ack=%b err=%b", ack_q[0], err_q[0], e.ack, e.err); end
            n_tests++; if (ack_cyc_q[0] - wr_cyc_q[0] != 4) begin n_fail++; $display("FAIL timeout_latency: got %0d, expected 4", ack_cyc_q[0] - wr_cyc_q[0]); end
            n_tests++; if (wr_len_q[0] !== wexp_q[0].len) begin n_fail++; $display("FAIL timeout_wr_len: got %0d, expected %0d", wr_len_q[0], wexp_q[0].len); end
        end
        repeat (3) step();
        tx_auto = 1'b1;
        clear_obs();
    endtask

    task automatic test_reset_mid();
        bit ok;
        busy_hold = 20;
        tx_auto = 1'b1;
        len1 = 8'd6;
        data1 = mk_data(8'h60);
        req = 3'b010;
        for (int k = 0; k < 20 && wr_cyc_q.size() == 0; k++) step();
        n_tests++; if (wr_cyc_q.size() == 0) begin n_fail++; $display("FAIL rstmid_wr_seen: got none, expected a launch"); end
        repeat (3) step();
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL rstmid_active_before: got %b, expected 1", active); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (active !== 1'b0 || grant_id !== 2'd3) begin n_fail++; $display("FAIL rstmid_owner: got active=%b grant_id=%0d, expected 0/3", active, grant_id); end
        n_tests++; if (tx_payload_len !== 8'd0 || tx_buf !== 128'd0 || tx_packet_wr !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx: got len=%0d buf=%h wr=%b, expected zeros", tx_payload_len, tx_buf, tx_packet_wr); end
        n_tests++; if (ack !== 3'b000 || err !== 3'b000) begin n_fail++; $display("FAIL rstmid_ack: got ack=%b err=%b, expected 000/000", ack, err); end
        busy_left = 0;
        tx_busy = 1'b0;
        req = 3'b000;
        repeat (3) step();
        n_tests++; if (ack_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d acks, expected 0", ack_q.size()); end
        rst_n = 1'b1;
        step();
        clear_obs();
        busy_hold = 3;
        len0 = 8'd2; len1 = 8'd3; len2 = 8'd4;
        data0 = mk_data(8'h70); data1 = mk_data(8'h80); data2 = mk_data(8'h90);
        req = 3'b111;
        wait_acks(1, 40, ok);
        req = 3'b000;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_first_timeout: got no ack, expected one"); end
        if (ok) begin
            n_tests++; if (ack_q[0] !== 3'b001) begin n_fail++; $display("FAIL rstmid_first_owner: got ack=%b, expected 001", ack_q[0]); end
        end
        if (wr_len_q.size() > 0) begin
            n_tests++; if (wr_len_q[0] !== 8'd2) begin n_fail++; $display("FAIL rstmid_first_len: got %0d, expected 2", wr_len_q[0]); end
        end
        repeat (6) step();
        clear_obs();
    endtask

    initial begin
        rst_n = 1'b0;
        req = 3'b000;
        tx_busy = 1'b0;
        len0 = '0; len1 = '0; len2 = '0;
        data0 = '0; data1 = '0; data2 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_len_reject();
        test_timeout();
        test_reset_mid();
        n_tests++; if (multi_ack != 0) begin n_fail++; $display("FAIL ack_onehot: got %0d multi-bit cycles, expected 0", multi_ack); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
